// File: rtl/repairmb_partner_responder.sv
// Partner-side responder for the MBINIT.REPAIRMB sideband handshake.
// Answers start/apply-degrade/end requests, latches the lane map and times out idle phases.
module repairmb_partner_responder #(
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_REVERSALMB_end,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic [2:0] i_msg_info,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_tx_data_valid_resp,
  output logic [1:0] o_Partner_Functional_Lanes,
  output logic       o_degrade_applied,
  output logic       o_repair_error,
  output logic       o_REPAIRMB_partner_end
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] MSG_START_REQ  = 4'd1;
  localparam logic [3:0] MSG_START_RESP = 4'd2;
  localparam logic [3:0] MSG_END_REQ    = 4'd3;
  localparam logic [3:0] MSG_END_RESP   = 4'd4;
  localparam logic [3:0] MSG_DEG_REQ    = 4'd5;
  localparam logic [3:0] MSG_DEG_RESP   = 4'd6;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WAIT_START = 4'd1,
    ARB_START  = 4'd2,
    SEND_START = 4'd3,
    WAIT_REQ   = 4'd4,
    ARB_DEG    = 4'd5,
    SEND_DEG   = 4'd6,
    ARB_END    = 4'd7,
    SEND_END   = 4'd8,
    DONE       = 4'd9,
    ERROR      = 4'd10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_latch;
  logic          w_timeout;
  logic          w_is_wait;
  logic [3:0]    w_tx_msg;
  logic          w_tx_valid;

  logic [3:0]    r_tx_msg;
  logic          r_tx_valid;
  logic [1:0]    r_lanes;
  logic          r_deg_applied;
  logic          r_error;
  logic          r_end;

  logic          w_unused_info;
  assign w_unused_info = i_msg_info[2];

  assign w_is_wait = (r_state == WAIT_START) || (r_state == WAIT_REQ);
  // A valid message in the last count cycle takes priority over the timeout
  assign w_timeout = !i_msg_valid && (r_cnt == TO_LAST);

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    if (!i_MBINIT_REVERSALMB_end) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_next = WAIT_START;
        WAIT_START: begin
          if (i_msg_valid && (i_RX_SbMessage == MSG_START_REQ)) begin
            w_next = ARB_START;
          end else if (w_timeout) begin
            w_next = ERROR;
          end else begin
            w_next = r_state;
          end
        end
        ARB_START: begin
          if (!i_Busy_SideBand) w_next = SEND_START;
          else                  w_next = r_state;
        end
        SEND_START: begin
          if (i_falling_edge_busy) w_next = WAIT_REQ;
          else                     w_next = r_state;
        end
        WAIT_REQ: begin
          if (i_msg_valid && (i_RX_SbMessage == MSG_DEG_REQ)) begin
            if (i_msg_info[1:0] != 2'b00) begin
              w_next  = ARB_DEG;
              w_latch = 1'b1;
            end else begin
              w_next = ERROR;
            end
          end else if (i_msg_valid && (i_RX_SbMessage == MSG_END_REQ)) begin
            w_next = ARB_END;
          end else if (i_msg_valid && (i_RX_SbMessage == MSG_START_REQ)) begin
            w_next = ARB_START;
          end else if (w_timeout) begin
            w_next = ERROR;
          end else begin
            w_next = r_state;
          end
        end
        ARB_DEG: begin
          if (!i_Busy_SideBand) w_next = SEND_DEG;
          else                  w_next = r_state;
        end
        SEND_DEG: begin
          if (i_falling_edge_busy) w_next = WAIT_REQ;
          else                     w_next = r_state;
        end
        ARB_END: begin
          if (!i_Busy_SideBand) w_next = SEND_END;
          else                  w_next = r_state;
        end
        SEND_END: begin
          if (i_falling_edge_busy) w_next = DONE;
          else                     w_next = r_state;
        end
        DONE:    w_next = r_state;
        ERROR:   w_next = r_state;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    if (!i_MBINIT_REVERSALMB_end || !w_is_wait || i_msg_valid || (w_next != r_state)) begin
      w_cnt_next = {CW{1'b0}};
    end else begin
      w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Response code is decoded from the next state so it lines up with the registered state
  always_comb begin
    w_tx_msg   = 4'd0;
    w_tx_valid = 1'b0;
    case (w_next)
      SEND_START: begin w_tx_msg = MSG_START_RESP; w_tx_valid = 1'b1; end
      SEND_DEG:   begin w_tx_msg = MSG_DEG_RESP;   w_tx_valid = 1'b1; end
      SEND_END:   begin w_tx_msg = MSG_END_RESP;   w_tx_valid = 1'b1; end
      default:    begin w_tx_msg = 4'd0;           w_tx_valid = 1'b0; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= {CW{1'b0}};
      r_tx_msg      <= 4'd0;
      r_tx_valid    <= 1'b0;
      r_lanes       <= 2'b11;
      r_deg_applied <= 1'b0;
      r_error       <= 1'b0;
      r_end         <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_next;
      r_tx_msg      <= w_tx_msg;
      r_tx_valid    <= w_tx_valid;
      r_deg_applied <= w_latch;
      r_error       <= (w_next == ERROR);
      r_end         <= (w_next == DONE);
      if (!i_MBINIT_REVERSALMB_end) begin
        r_lanes <= 2'b11;
      end else if (w_latch) begin
        r_lanes <= i_msg_info[1:0];
      end else begin
        r_lanes <= r_lanes;
      end
    end
  end

  assign o_TX_SbMessage             = r_tx_msg;
  assign o_tx_data_valid_resp       = r_tx_valid;
  assign o_Partner_Functional_Lanes = r_lanes;
  assign o_degrade_applied          = r_deg_applied;
  assign o_repair_error             = r_error;
  assign o_REPAIRMB_partner_end     = r_end;

endmodule

// File: tb/tb_repairmb_partner_responder.sv
// Scoreboard bench for repairmb_partner_responder: expected TX codes are queued at request
// time and popped by a monitor on each rising TX valid; directed checks cover the rest.
module tb_repairmb_partner_responder;

  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] rx_msg;
  logic       msg_valid;
  logic [2:0] msg_info;
  logic       busy;
  logic       fall;
  logic [3:0] o_tx_msg;
  logic       o_valid;
  logic [1:0] o_lanes;
  logic       o_deg;
  logic       o_err;
  logic       o_end;

  int  n_vec = 0;
  int  n_err = 0;
  int  exp_q[$];
  logic prev_valid = 1'b0;

  bit   tx_auto = 1'b0;
  logic man_busy = 1'b0;
  logic man_fall = 1'b0;
  logic m_busy = 1'b0;
  logic m_fall = 1'b0;
  int   m_cnt = 0;

  assign busy = tx_auto ? m_busy : man_busy;
  assign fall = tx_auto ? m_fall : man_fall;

  always #5 CLK = ~CLK;

  repairmb_partner_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK                        (CLK),
    .rst_n                      (rst_n),
    .i_MBINIT_REVERSALMB_end    (en),
    .i_RX_SbMessage             (rx_msg),
    .i_msg_valid                (msg_valid),
    .i_msg_info                 (msg_info),
    .i_Busy_SideBand            (busy),
    .i_falling_edge_busy        (fall),
    .o_TX_SbMessage             (o_tx_msg),
    .o_tx_data_valid_resp       (o_valid),
    .o_Partner_Functional_Lanes (o_lanes),
    .o_degrade_applied          (o_deg),
    .o_repair_error             (o_err),
    .o_REPAIRMB_partner_end     (o_end)
  );

  // Simple sideband TX: busy for three cycles after a request, then a falling-edge pulse
  always @(negedge CLK) begin
    if (!tx_auto) begin
      m_busy = 1'b0;
      m_fall = 1'b0;
      m_cnt  = 0;
    end else if (m_fall) begin
      m_fall = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_fall = 1'b1;
      end
    end else if (o_valid && !m_busy) begin
      m_busy = 1'b1;
      m_cnt  = 3;
    end
  end

  // Scoreboard monitor
  always @(negedge CLK) begin
    int e;
    if (o_valid && !prev_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got msg %0d, none expected", o_tx_msg);
      end else begin
        e = exp_q.pop_front();
        if (int'(o_tx_msg) != e) begin
          n_err++;
          $display("FAIL tx_msg: got %0d expected %0d", o_tx_msg, e);
        end
      end
    end
    prev_valid = o_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; message is sampled at the following posedge
  task automatic send_msg(input logic [3:0] m, input logic [2:0] info, input int push);
    rx_msg    = m;
    msg_info  = info;
    msg_valid = 1'b1;
    if (push != 0) exp_q.push_back(push);
    @(negedge CLK);
    msg_valid = 1'b0;
    rx_msg    = 4'd0;
    msg_info  = 3'd0;
  endtask

  task automatic wait_tx_done(input string name);
    int k;
    k = 0;
    while (!o_valid && k < 30) begin @(negedge CLK); k++; end
    chk({name, "_rise"}, int'(o_valid), 1);
    k = 0;
    while (o_valid && k < 30) begin @(negedge CLK); k++; end
    chk({name, "_drop"}, int'(o_valid), 0);
  endtask

  task automatic restart_phase();
    en = 1'b0;
    @(negedge CLK);
    en = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    logic [9:0] obs;
    rst_n = 1'b0; en = 1'b0; rx_msg = 4'd0; msg_valid = 1'b0; msg_info = 3'd0;
    repeat (3) @(negedge CLK);
    obs = {o_tx_msg, o_valid, o_lanes, o_deg, o_err, o_end};
    chk("reset_outputs", int'(obs), int'(10'b0000_0_11_0_0_0));
    rst_n = 1'b1;
    @(negedge CLK);

    // Nominal flow: start, full-width degrade, end
    tx_auto = 1'b1;
    restart_phase();
    send_msg(4'd1, 3'd0, 2);
    wait_tx_done("start");
    send_msg(4'd5, 3'b011, 6);
    chk("nom_deg_pulse", int'(o_deg), 1);
    chk("nom_lanes", int'(o_lanes), 3);
    @(negedge CLK);
    chk("nom_deg_single", int'(o_deg), 0);
    wait_tx_done("deg");
    send_msg(4'd3, 3'd0, 4);
    wait_tx_done("end");
    chk("nom_end_high", int'(o_end), 1);
    repeat (3) @(negedge CLK);
    chk("nom_end_held", int'(o_end), 1);

    // Half-width degrade sequence, then a zero-lane request
    en = 1'b0;
    @(negedge CLK);
    chk("en_low_end_clear", int'(o_end), 0);
    chk("en_low_lanes", int'(o_lanes), 3);
    en = 1'b1;
    @(negedge CLK);
    send_msg(4'd1, 3'd0, 2);
    wait_tx_done("start2");
    send_msg(4'd5, 3'b001, 6);
    chk("half_lower_lanes", int'(o_lanes), 1);
    chk("half_lower_pulse", int'(o_deg), 1);
    wait_tx_done("deg_lower");
    send_msg(4'd5, 3'b010, 6);
    chk("half_upper_lanes", int'(o_lanes), 2);
    chk("half_upper_pulse", int'(o_deg), 1);
    wait_tx_done("deg_upper");
    send_msg(4'd5, 3'b000, 0);
    chk("zero_err", int'(o_err), 1);
    chk("zero_no_valid", int'(o_valid), 0);
    chk("zero_no_pulse", int'(o_deg), 0);
    repeat (4) @(negedge CLK);
    chk("zero_err_sticky", int'(o_err), 1);
    chk("zero_lanes_hold", int'(o_lanes), 2);
    en = 1'b0;
    @(negedge CLK);
    chk("zero_err_cleared", int'(o_err), 0);
    chk("zero_lanes_reset", int'(o_lanes), 3);

    // Timeout: 16 idle cycles in WAIT_REQ -> ERROR
    en = 1'b1;
    @(negedge CLK);
    send_msg(4'd1, 3'd0, 2);
    wait_tx_done("start_to");
    repeat (TO - 1) @(negedge CLK);
    chk("to_not_yet", int'(o_err), 0);
    @(negedge CLK);
    chk("to_error", int'(o_err), 1);

    // Request in the last count cycle beats the timeout
    restart_phase();
    send_msg(4'd1, 3'd0, 2);
    wait_tx_done("start_to2");
    repeat (TO - 1) @(negedge CLK);
    send_msg(4'd3, 3'd0, 4);
    chk("to_saved_no_err", int'(o_err), 0);
    wait_tx_done("end_to2");
    chk("to_saved_end", int'(o_end), 1);

    // Busy arbitration with manual sideband control
    tx_auto  = 1'b0;
    man_busy = 1'b1;
    restart_phase();
    send_msg(4'd1, 3'd0, 2);
    for (int i = 0; i < 4; i++) begin
      chk("arb_valid_low", int'(o_valid), 0);
      @(negedge CLK);
    end
    chk("arb_valid_low_last", int'(o_valid), 0);
    man_busy = 1'b0;
    @(negedge CLK);
    chk("arb_valid_rise", int'(o_valid), 1);
    chk("arb_msg", int'(o_tx_msg), 2);
    send_msg(4'd3, 3'd0, 0);
    chk("send_ignores_end", int'(o_valid), 1);
    man_fall = 1'b1;
    @(negedge CLK);
    man_fall = 1'b0;
    chk("send_done_valid", int'(o_valid), 0);
    repeat (2) @(negedge CLK);
    chk("ignored_end_no_valid", int'(o_valid), 0);
    chk("ignored_end_no_done", int'(o_end), 0);

    // Reset while sending a degrade response
    send_msg(4'd5, 3'b001, 6);
    @(negedge CLK);
    chk("pre_rst_valid", int'(o_valid), 1);
    chk("pre_rst_lanes", int'(o_lanes), 1);
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    obs = {o_tx_msg, o_valid, o_lanes, o_deg, o_err, o_end};
    chk("mid_send_reset", int'(obs), int'(10'b0000_0_11_0_0_0));

    @(negedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
